cp0_regfile: RTL

- Coprocessor-0 register file and exception sequencer for the 5-stage pipelined MIPS core.
- Services mfc0 reads and mtc0 writes, and latches hardware interrupt lines.
- Performs exception/interrupt entry (EPC capture, EXL set) and eret return.
- The CP0 forwarding path and PC-select logic consume its read data, EPC output and redirect requests.

---
 rtl/cp0_pkg.sv | 43 ++++
 rtl/cp0_timer.sv | 59 +++++
 rtl/cp0_regfile.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, ExcCodes and
// register packing helpers used by the register file and its timer.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int IM_LSB         = 10;
    localparam int IM_MSB         = 15;
    localparam int IP_LSB         = 10;
    localparam int IP_MSB         = 15;
    localparam int EXC_LSB        = 2;
    localparam int EXC_MSB        = 6;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    // EXL doubles as the sequencer state bit
    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_e;

    function automatic logic [31:0] pack_status(input logic [5:0] im,
                                                input logic       exl,
                                                input logic       ie);
        return {16'd0, im, 8'd0, exl, ie};
    endfunction

    function automatic logic [31:0] pack_cause(input logic [5:0] ip,
                                               input logic [4:0] code);
        return {16'd0, ip, 3'd0, code, 2'd0};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky match flag; only built when CP0_TIMER_EN
// is defined.
module cp0_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we_i,
    input  logic [31:0] count_wdata_i,
    input  logic        compare_we_i,
    input  logic [31:0] compare_wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        pending_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pending_q, pending_d;
    logic [31:0] count_inc_s;

    assign count_inc_s = count_q + 32'd1;

    // Next-state: a Count load beats the increment, a Compare write clears the flag
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        pending_d = pending_q;
        if (count_we_i) begin
            count_d = count_wdata_i;
        end else begin
            count_d = count_inc_s;
        end
        if (compare_we_i) begin
            compare_d = compare_wdata_i;
            pending_d = 1'b0;
        end else if (!count_we_i && (count_inc_s == compare_q)) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Timer state flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file and exception/eret sequencer for the 5-stage MIPS core.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic        int_req,
    output logic        exc_redirect,
    output logic [31:0] exc_target,
    output logic [31:0] epc_out,
    output logic [31:0] status_out,
    output logic [31:0] cause_out
);

    cp0_state_e  state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic [5:0]  ip_q;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] epc_q, epc_d;

    logic        exl_s;
    logic [5:0]  ip_eff_s;
    logic        int_req_s;
    logic        entry_s;
    logic        wr_status_s;
    logic        wr_epc_s;
    logic        reg_writable_s;
    logic [31:0] rdata_s;
    logic [31:0] count_s;
    logic [31:0] compare_s;
    logic        timer_pend_s;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk             (clk),
        .rst_n           (rst_n),
        .count_we_i      (mtc0_we && (cp0_waddr == CP0_COUNT)),
        .count_wdata_i   (cp0_wdata),
        .compare_we_i    (mtc0_we && (cp0_waddr == CP0_COMPARE)),
        .compare_wdata_i (cp0_wdata),
        .count_o         (count_s),
        .compare_o       (compare_s),
        .pending_o       (timer_pend_s)
    );
`else
    assign count_s      = 32'd0;
    assign compare_s    = 32'd0;
    assign timer_pend_s = 1'b0;
`endif

    assign exl_s       = (state_q == ST_HANDLER);
    assign ip_eff_s    = ip_q | {timer_pend_s, 5'd0};
    assign int_req_s   = ie_q & ~exl_s & (|(ip_eff_s & im_q)) & ~exc_req;
    assign entry_s     = exc_req | int_req_s;
    assign wr_status_s = mtc0_we && (cp0_waddr == CP0_STATUS);
    assign wr_epc_s    = mtc0_we && (cp0_waddr == CP0_EPC);

    // Next-state: entry beats eret beats mtc0; non-conflicting mtc0 fields still land
    always_comb begin
        state_d    = state_q;
        im_d       = im_q;
        ie_d       = ie_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        if (wr_status_s) begin
            im_d = cp0_wdata[IM_MSB:IM_LSB];
            ie_d = cp0_wdata[STATUS_IE_BIT];
        end else begin
            im_d = im_q;
            ie_d = ie_q;
        end

        if (entry_s) begin
            state_d = ST_HANDLER;
        end else if (eret) begin
            state_d = ST_NORMAL;
        end else if (wr_status_s) begin
            state_d = cp0_wdata[STATUS_EXL_BIT] ? ST_HANDLER : ST_NORMAL;
        end else begin
            state_d = state_q;
        end

        if (entry_s) begin
            epc_d      = exc_pc;
            exc_code_d = exc_req ? exc_code : EXC_INT;
        end else if (wr_epc_s) begin
            epc_d      = cp0_wdata;
            exc_code_d = exc_code_q;
        end else begin
            epc_d      = epc_q;
            exc_code_d = exc_code_q;
        end
    end

    // CP0 architectural state; IP samples the interrupt lines every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_NORMAL;
            im_q       <= 6'd0;
            ie_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            im_q       <= im_d;
            ie_q       <= ie_d;
            ip_q       <= hw_int;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    // Registers that accept mtc0 and therefore participate in the read bypass
    always_comb begin
        reg_writable_s = 1'b0;
        case (cp0_waddr)
            CP0_STATUS:  reg_writable_s = 1'b1;
            CP0_EPC:     reg_writable_s = 1'b1;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   reg_writable_s = 1'b1;
            CP0_COMPARE: reg_writable_s = 1'b1;
`endif
            default:     reg_writable_s = 1'b0;
        endcase
    end

    // mfc0 read mux with same-cycle mtc0 bypass
    always_comb begin
        rdata_s = 32'd0;
        case (cp0_raddr)
            CP0_COUNT:   rdata_s = count_s;
            CP0_COMPARE: rdata_s = compare_s;
            CP0_STATUS:  rdata_s = status_out;
            CP0_CAUSE:   rdata_s = cause_out;
            CP0_EPC:     rdata_s = epc_q;
            CP0_PRID:    rdata_s = PRID_VAL;
            default:     rdata_s = 32'd0;
        endcase
        if (mtc0_we && (cp0_raddr == cp0_waddr) && reg_writable_s) begin
            cp0_rdata = cp0_wdata;
        end else begin
            cp0_rdata = rdata_s;
        end
    end

    assign status_out   = pack_status(im_q, exl_s, ie_q);
    assign cause_out    = pack_cause(ip_eff_s, exc_code_q);
    assign epc_out      = wr_epc_s ? cp0_wdata : epc_q;
    assign int_req      = int_req_s;
    assign exc_redirect = entry_s;
    assign exc_target   = EXC_VECTOR;

endmodule
